multicycle_controller: RTL

Sequencing FSM for the multicycle version of the core. It drives a shared-datapath implementation (one ALU, one unified instruction/data memory, IR/MDR/A/B/ALUOut latches) of the existing ISA. Instructions take 2–5 states. Memory accesses use a req/ready handshake so the memory can stall the FSM. It sits between the instruction register opcode/ALU zero flag and every datapath enable and mux select.

---
 rtl/multicycle_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle core: drives every datapath enable and mux select.
// Optional retired-instruction counter is built when PERF_CNT_EN is defined.
module multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [3:0]  state_dbg
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] instr_retired
`endif
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned ST_W  = 4;
    localparam int unsigned CNT_W = 32;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(32);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(34);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(10);

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_LT  = ALU_W'(4);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_WB_LW    = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    state_t r_state;

    logic w_op_rtype;
    logic w_op_mem;
    logic w_op_br;
    logic w_op_jmp;

    // Opcode class decode, only meaningful from DECODE onward
    always_comb begin
        w_op_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND) ||
                     (opcode == OP_OR)  || (opcode == OP_SLT);
        w_op_mem   = (opcode == OP_LW)  || (opcode == OP_SW);
        w_op_br    = (opcode == OP_BEQ) || (opcode == OP_BNE);
        w_op_jmp   = (opcode == OP_JMP);
    end

    // State sequencing; memory states hold until mem_ready, stray codes recover to FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_op_rtype)    r_state <= S_EXEC_R;
                    else if (w_op_mem) r_state <= S_MEM_ADDR;
                    else if (w_op_br)  r_state <= S_BRANCH;
                    else if (w_op_jmp) r_state <= S_JUMP;
                    else               r_state <= S_FETCH;
                end
                S_EXEC_R:   r_state <= S_WB_R;
                S_WB_R:     r_state <= S_FETCH;
                S_MEM_ADDR: r_state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) r_state <= S_WB_LW;
                S_WB_LW:    r_state <= S_FETCH;
                S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JUMP:     r_state <= S_FETCH;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Control decode; reset forces everything low so an aborted request drops at once
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        state_dbg  = rst ? ST_W'(0) : ST_W'(r_state);
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'd3;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_AND:  alu_op = ALU_AND;
                        OP_OR:   alu_op = ALU_OR;
                        OP_SLT:  alu_op = ALU_LT;
                        default: alu_op = ALU_ADD;
                    endcase
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_WB_LW: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 2'd1;
                    pc_write  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                end
                S_JUMP: begin
                    pc_src   = 2'd2;
                    pc_write = 1'b1;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // An instruction retires on every completing transition back into FETCH
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_WB_R, S_WB_LW, S_BRANCH, S_JUMP: w_retire = 1'b1;
            S_MEM_WR: w_retire = mem_ready;
            S_DECODE: w_retire = !(w_op_rtype || w_op_mem || w_op_br || w_op_jmp);
            default:  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= CNT_W'(0);
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign instr_retired = rst ? CNT_W'(0) : r_retired;
`endif

endmodule
